// File: rtl/wash_panel_ctrl.sv
// rtl/wash_panel_ctrl.sv - washing-machine front-panel controller
//
// Debounces the start/pause/cancel buttons, latches the wash options at launch,
// drives the washer start/pause requests and tracks completion via done.
//
// Ports:
//   clk          in   system clock (one tick per second of machine time)
//   rst_n        in   asynchronous active-low reset
//   btn_start    in   raw start button (asynchronous, bouncy)
//   btn_pause    in   raw pause button (asynchronous, bouncy)
//   btn_cancel   in   raw cancel button (asynchronous, bouncy)
//   sw_double    in   double-wash selector level
//   sw_dry       in   dry-wash selector level
//   done         in   washer done flag (synchronous)
//   start        out  start request to washer
//   double_wash  out  latched double-wash option
//   dry_wash     out  latched dry-wash option
//   time_pause   out  pause request to washer
//   wm_cancel_n  out  active-low one-clock abort strobe
//   busy         out  high while launching, running or paused
//   complete_led out  high while the finished cycle is displayed

module wash_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned START_HOLD      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start,
  input  logic btn_pause,
  input  logic btn_cancel,
  input  logic sw_double,
  input  logic sw_dry,
  input  logic done,
  output logic start,
  output logic double_wash,
  output logic dry_wash,
  output logic time_pause,
  output logic wm_cancel_n,
  output logic busy,
  output logic complete_led
);

  localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HCW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(START_HOLD - 1);

  // Bit 0 = start, bit 1 = pause, bit 2 = cancel.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_cancel, btn_pause, btn_start};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic           sync1_q;
    logic           sync2_q;
    logic           deb_q;
    logic           deb_prev_q;
    logic           press_q;
    logic [DCW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        press_q    <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q <= btn_raw[b];
        sync2_q <= sync1_q;
        // Count consecutive clocks where the synchronised level disagrees with
        // the accepted level; any agreement restarts the count.
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_q <= '0;
          deb_q <= sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        deb_prev_q <= deb_q;
        press_q    <= deb_q & ~deb_prev_q;
      end
    end

    assign press[b] = press_q;
  end

  logic start_p;
  logic pause_p;
  logic cancel_p;

  assign start_p  = press[0];
  assign pause_p  = press[1];
  assign cancel_p = press[2];

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUNNING,
    S_PAUSED,
    S_COMPLETE
  } state_e;

  state_e         state_q, state_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           done_q;
  logic           done_rise;
  logic           start_q, start_d;
  logic           dw_q, dw_d;
  logic           dry_q, dry_d;
  logic           tp_q, tp_d;
  logic           cn_q, cn_d;
  logic           busy_q, busy_d;
  logic           led_q, led_d;

  assign done_rise = done & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      dw_q    <= 1'b0;
      dry_q   <= 1'b0;
      tp_q    <= 1'b0;
      cn_q    <= 1'b1;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      done_q  <= done;
      start_q <= start_d;
      dw_q    <= dw_d;
      dry_q   <= dry_d;
      tp_q    <= tp_d;
      cn_q    <= cn_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    start_d = start_q;
    dw_d    = dw_q;
    dry_d   = dry_q;
    tp_d    = tp_q;
    cn_d    = 1'b1;

    if (cancel_p && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      start_d = 1'b0;
      tp_d    = 1'b0;
      dw_d    = 1'b0;
      dry_d   = 1'b0;
      cn_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_COMPLETE: begin
          // A simultaneous cancel still outranks start, even where cancel
          // itself has nothing to abort.
          if (start_p && !cancel_p) begin
            state_d = S_LAUNCH;
            start_d = 1'b1;
            hold_d  = '0;
            dw_d    = sw_double;
            dry_d   = sw_dry;
          end
        end
        S_LAUNCH: begin
          if (hold_q == HOLD_LAST) begin
            start_d = 1'b0;
            state_d = S_RUNNING;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        S_RUNNING: begin
          tp_d = 1'b0;
          if (done_rise) begin
            state_d = S_COMPLETE;
          end else if (pause_p) begin
            state_d = S_PAUSED;
            tp_d    = 1'b1;
          end
        end
        S_PAUSED: begin
          tp_d = 1'b1;
          if (done_rise) begin
            state_d = S_COMPLETE;
            tp_d    = 1'b0;
          end else if (pause_p) begin
            state_d = S_RUNNING;
            tp_d    = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Status outputs follow the next state so they line up with it in time.
    busy_d = (state_d == S_LAUNCH) || (state_d == S_RUNNING) || (state_d == S_PAUSED);
    led_d  = (state_d == S_COMPLETE);
  end

  assign start        = start_q;
  assign double_wash  = dw_q;
  assign dry_wash     = dry_q;
  assign time_pause   = tp_q;
  assign wm_cancel_n  = cn_q;
  assign busy         = busy_q;
  assign complete_led = led_q;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// tb/tb_wash_panel_ctrl.sv - directed bench for wash_panel_ctrl

module tb_wash_panel_ctrl;

  logic clk;
  logic rst_n;
  logic btn_start, btn_pause, btn_cancel;
  logic sw_double, sw_dry, done;
  logic start, double_wash, dry_wash, time_pause, wm_cancel_n, busy, complete_led;

  int checks = 0;
  int errors = 0;

  wash_panel_ctrl #(.DEBOUNCE_CYCLES(3), .START_HOLD(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_start    (btn_start),
    .btn_pause    (btn_pause),
    .btn_cancel   (btn_cancel),
    .sw_double    (sw_double),
    .sw_dry       (sw_dry),
    .done         (done),
    .start        (start),
    .double_wash  (double_wash),
    .dry_wash     (dry_wash),
    .time_pause   (time_pause),
    .wm_cancel_n  (wm_cancel_n),
    .busy         (busy),
    .complete_led (complete_led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, landing 1 time unit after the last rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    if (b == 0) btn_start = 1'b1;
    if (b == 1) btn_pause = 1'b1;
    if (b == 2) btn_cancel = 1'b1;
    step(7);
    btn_start  = 1'b0;
    btn_pause  = 1'b0;
    btn_cancel = 1'b0;
    step(7);
  endtask

  // Press start and record when start first rises, how long it stays high,
  // and complete_led at that moment.
  task automatic launch_measure(output int first, output int count, output logic led_at);
    first  = -1;
    count  = 0;
    led_at = 1'bx;
    btn_start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (start === 1'b1) begin
        if (first < 0) begin
          first  = i;
          led_at = complete_led;
        end
        count++;
      end
    end
    btn_start = 1'b0;
    step(7);
  endtask

  int   first, count, cn_low, tp_high, st_high, busy_high;
  logic led_at, dw_at_cancel;

  initial begin
    rst_n = 1'b0;
    btn_start = 0; btn_pause = 0; btn_cancel = 0;
    sw_double = 0; sw_dry = 0; done = 0;
    step(3);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cancel_n", wm_cancel_n, 1);
    chk("rst_led", complete_led, 0);
    chk("rst_opts", {double_wash, dry_wash, time_pause}, 0);
    rst_n = 1'b1;
    step(2);

    // 1: bouncy start, then stable high; start rises 6 clocks after stable.
    sw_double = 1; sw_dry = 0;
    st_high = 0;
    for (int i = 0; i < 6; i++) begin
      btn_start = (i % 2 == 0);
      step(1);
      if (start) st_high++;
    end
    btn_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (start) st_high++;
    end
    chk("t1_no_early_start", st_high, 0);
    step(1);
    chk("t1_start_hi", start, 1);
    chk("t1_busy", busy, 1);
    step(1);
    chk("t1_start_lo", start, 0);
    chk("t1_busy_run", busy, 1);
    st_high = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (start) st_high++;
    end
    chk("t1_single_pulse", st_high, 0);
    chk("t1_opts", {double_wash, dry_wash}, 2'b10);

    // 2: switch changes mid-cycle are ignored.
    sw_double = 0; sw_dry = 1;
    btn_start = 0;
    step(7);
    chk("t2_opts_frozen", {double_wash, dry_wash}, 2'b10);

    // 3: pause toggling; start while paused does nothing.
    press(1);
    chk("t3_paused", time_pause, 1);
    chk("t3_busy_paused", busy, 1);
    launch_measure(first, count, led_at);
    chk("t3_no_start_paused", count, 0);
    chk("t3_still_paused", time_pause, 1);
    press(1);
    chk("t3_resumed", time_pause, 0);
    chk("t3_opts_frozen", {double_wash, dry_wash}, 2'b10);

    // 4: done rise completes; relaunch with done still high.
    done = 1'b1;
    step(1);
    chk("t4_led", complete_led, 1);
    chk("t4_busy", busy, 0);
    step(4);
    chk("t4_led_hold", complete_led, 1);
    launch_measure(first, count, led_at);
    chk("t4_start_latency", first, 6);
    chk("t4_start_width", count, 1);
    chk("t4_led_at_launch", led_at, 0);
    chk("t4_busy_run", busy, 1);
    chk("t4_led_off", complete_led, 0);
    chk("t4_relatch", {double_wash, dry_wash}, 2'b01);

    // 5: cancel and pause in the same clock while running.
    done = 1'b0;
    cn_low = 0; tp_high = 0; dw_at_cancel = 1'bx;
    btn_cancel = 1'b1; btn_pause = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (wm_cancel_n === 1'b0) begin
        cn_low++;
        dw_at_cancel = dry_wash;
      end
      if (time_pause) tp_high++;
      if (i == 6) begin
        btn_cancel = 1'b0; btn_pause = 1'b0;
      end
    end
    chk("t5_cancel_width", cn_low, 1);
    chk("t5_dry_cleared_at_cancel", dw_at_cancel, 0);
    chk("t5_no_pause", tp_high, 0);
    chk("t5_idle", {busy, complete_led, start}, 0);
    chk("t5_opts_clear", {double_wash, dry_wash}, 0);
    step(7);

    // 6: asynchronous reset while paused, then a short glitch does not launch.
    sw_double = 1; sw_dry = 1;
    press(0);
    press(1);
    chk("t6_paused", {time_pause, busy, double_wash, dry_wash}, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst_outs", {start, double_wash, dry_wash, time_pause, busy, complete_led}, 0);
    chk("t6_async_rst_cn", wm_cancel_n, 1);
    step(3);
    rst_n = 1'b1;
    btn_start = 1'b1;
    step(2);
    btn_start = 1'b0;
    busy_high = 0; st_high = 0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (busy) busy_high++;
      if (start) st_high++;
    end
    chk("t6_no_launch_busy", busy_high, 0);
    chk("t6_no_launch_start", st_high, 0);
    press(0);
    chk("t6_launch_after", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
